// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the divide helper used to form HI/LO results.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Returns {remainder, quotient}. Signed mode divides magnitudes and then
  // restores signs, so 0x8000_0000 / -1 wraps to 0x8000_0000 with remainder 0.
  function automatic logic [63:0] md_divide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] res;
    abs_a = (is_signed && a[31]) ? (32'd0 - a) : a;
    abs_b = (is_signed && b[31]) ? (32'd0 - b) : b;
    q     = 32'd0;
    r     = 32'd0;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q = abs_a / abs_b;
      r = abs_a % abs_b;
      if (is_signed && (a[31] ^ b[31])) q = 32'd0 - q;
      if (is_signed && a[31])           r = 32'd0 - r;
      res = {r, q};
    end
    return res;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with HI/LO registers; results are formed at
// start and committed after a counted latency. MD_MADD_EN adds MADD/MSUB(U).
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
`ifdef MD_MADD_EN
  input  logic        md_uns,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_nx_q, hi_nx_d;
  logic [31:0]      lo_nx_q, lo_nx_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_s;
  logic [63:0] div_u;

  // Low 64 bits of a product of extended operands equal the 32x32 product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign div_s  = md_divide(A, B, 1'b1);
  assign div_u  = md_divide(A, B, 1'b0);

`ifdef MD_MADD_EN
  logic [63:0] acc_prod;
  logic [63:0] acc_res;
  assign acc_prod = md_uns ? prod_u : prod_s;
  assign acc_res  = (md_op == MD_MSUB) ? ({hi_q, lo_q} - acc_prod)
                                       : ({hi_q, lo_q} + acc_prod);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_nx_q <= 32'd0;
      lo_nx_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {hi_nx_d, lo_nx_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_MULTU: begin
              {hi_nx_d, lo_nx_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_DIV: begin
              {hi_nx_d, lo_nx_d} = div_s;
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_DIVU: begin
              {hi_nx_d, lo_nx_d} = div_u;
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
`ifdef MD_MADD_EN
            MD_MADD, MD_MSUB: begin
              {hi_nx_d, lo_nx_d} = acc_res;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // A start arriving here is dropped; the hazard unit stalls it upstream.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_nx_q;
          lo_d    = lo_nx_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
